cla_pipelined_adder: RTL and testbench
======================================

# cla_pipelined_adder

Parametrised, pipelined carry-lookahead adder with valid/ready handshakes on input and output. Operands are split into fixed-width lookahead groups, with one group resolved per pipeline stage, so that wide adds close timing at the datapath clock. It is the next generation of the team's 4-bit combinational `carry_lookahead` adder and is intended as the shared add unit for the ALU and accumulator datapaths.

## Interface
- `WIDTH`, 16, operand and sum width; must be a multiple of `GROUP`
- `GROUP`, 4, bits resolved by one lookahead group per stage
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operand beat valid
- `in_ready`  output  1  adder accepts a beat this cycle
- `a`  input  WIDTH  operand A
- `b`  input  WIDTH  operand B
- `cin`  input  1  carry in
- `out_valid`  output  1  result beat valid
- `out_ready`  input  1  downstream accepts the result
- `sum`  output  WIDTH  a + b + cin, modulo 2^WIDTH
- `cout`  output  1  carry out of bit WIDTH-1
- `ovf`  output  1  signed overflow; present only with `CLA_OVF_EN`

## Operation
- Stage count is S = WIDTH/GROUP. Stage k computes bits [k·GROUP +: GROUP] with one combinational GROUP-bit lookahead group: g_i = a_i&b_i, p_i = a_i^b_i, with group G/P feeding the carry.
- Each stage register holds:
  - its group-carry out,
  - the already-resolved low sum bits,
  - the still-unprocessed high operand bits,
  - a valid bit.
- Stage 0 takes `cin`. Stage k takes the registered carry of stage k-1.
- Global advance enable: en = !out_valid || out_ready. When en=0, all stages hold and bubbles are not collapsed.
- `in_ready` = en, combinational. A beat is accepted when in_valid && in_ready.
- When en=1, a stage whose predecessor is invalid loads valid=0. Data in invalid stages is don't-care.
- Results leave in acceptance order, one per cycle at full throughput.
- `cout` is the carry out of stage S-1.
- `ovf` = carry into the MSB XOR `cout`, registered alongside the final stage.

## Timing
- Latency is exactly S cycles from the accepting edge to out_valid=1, with no backpressure.
- Throughput is one beat per cycle when out_ready stays high.
- Backpressure:
  - out_valid && !out_ready freezes the whole pipe and drives in_ready low in the same cycle.
  - sum/cout/ovf stay stable until the transfer.
- Reset:
  - every stage valid bit clears to 0;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and never appear at the output. A beat presented in the reset cycle is not accepted.
- Simultaneous output transfer and input accept in one cycle is legal and loses no beat.
- Wrap-around: all-ones + 1 gives sum=0 and cout=1. No saturation.
- S=1 (WIDTH=GROUP) degenerates to a single registered CLA with latency 1.

## Configuration
- `CLA_OVF_EN` defined: the `ovf` port exists and an MSB-carry pipeline bit is carried in the final stage.
- `CLA_OVF_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `cla_pkg`:
  - default `GROUP` constant;
  - a struct typedef for the stage register (valid, carry, low-sum, high-operand fields);
  - a G/P helper function.
- Sub-module `cla_group`: combinational GROUP-bit lookahead producing sum bits, group carry out and the MSB carry-in. It is instantiated once per stage in a generate loop.

## Test plan
- Reset then idle:
  - in the cycle after rst deasserts, out_valid=0, sum=0, cout=0, in_ready=1;
  - out_valid stays 0 for 10 cycles with in_valid=0.
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, exactly 4 cycles after accept. With `CLA_OVF_EN`, ovf=0.
- Back-to-back stream:
  - beats (16'h1234+16'h4321, cin 0), (16'h8000+16'h8000, cin 1), (16'h7FFF+16'h0001, cin 0);
  - expected outputs on consecutive cycles: 5555/0, 0001/1, 8000/0;
  - with `CLA_OVF_EN`, ovf = 0, 1, 1.
- Backpressure:
  - hold out_ready=0 for 5 cycles while a result is valid;
  - in_ready=0 throughout and sum stays stable;
  - after release, all beats emerge in order with none lost or duplicated.
- Reset mid-flight: accept 3 beats, pulse rst at cycle 2 → no result ever appears and out_valid=0.
- Parametric sweep:
  - WIDTH/GROUP = 4/4, 8/4, 32/8, with 1000 random beats and random out_ready;
  - every result matches a + b + cin, and latency equals WIDTH/GROUP cycles plus the stall cycles.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
//   CLA_GROUP     : default number of bits resolved per lookahead group/stage
//   CLA_MAX_WIDTH : widest operand the stage register can carry
//   cla_stage_t   : one pipeline stage register (valid, carry, low sum, operands)
//   cla_bit_gp()  : per-bit generate/propagate
package cla_pkg;

  localparam int unsigned CLA_GROUP     = 4;
  localparam int unsigned CLA_MAX_WIDTH = 64;

  // Fields are sized for the widest supported adder; narrower builds keep the
  // upper bits at zero. Sum bits below the current stage are resolved, operand
  // bits at and above it are still pending.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [CLA_MAX_WIDTH-1:0] sum;
    logic [CLA_MAX_WIDTH-1:0] a;
    logic [CLA_MAX_WIDTH-1:0] b;
  } cla_stage_t;

  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  function automatic cla_gp_t cla_bit_gp(input logic a, input logic b);
    cla_gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead group.
//   a, b   : GROUP-bit operand slices
//   cin    : carry into the group's LSB
//   sum    : GROUP-bit sum slice
//   cout   : carry out of the group's MSB
//   c_msb  : carry into the group's MSB (used for signed overflow)
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  cla_gp_t          gp_i;
  logic             run_g;
  logic             run_p;

  // Every carry is a flat function of the prefix G/P and cin, not a ripple.
  always_comb begin
    g     = '0;
    p     = '0;
    c     = '0;
    gp_i  = '0;
    run_g = 1'b0;
    run_p = 1'b1;
    for (int unsigned i = 0; i < GROUP; i++) begin
      gp_i = cla_bit_gp(a[i], b[i]);
      g[i] = gp_i.g;
      p[i] = gp_i.p;
    end
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      run_g    = g[i] | (p[i] & run_g);
      run_p    = p[i] & run_p;
      c[i+1]   = run_g | (run_p & cin);
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder, one GROUP-bit lookahead group per stage,
// valid/ready on both sides. Optional signed overflow output via CLA_OVF_EN.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin            : operands and carry in
//   out_valid / out_ready: result handshake
//   sum, cout            : a + b + cin modulo 2^WIDTH, carry out
//   ovf                  : signed overflow (only when CLA_OVF_EN is defined)
module cla_pipelined_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STAGES = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH > CLA_MAX_WIDTH) begin : g_bad_cfg
    $error("cla_pipelined_adder: WIDTH must be a multiple of GROUP and fit the stage register");
  end

  logic       en;
  logic       ovf_d;
  cla_stage_t stg_q [STAGES];

  // Whole pipe advances together; bubbles are kept, never collapsed.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_stage_t       src;
    cla_stage_t       nxt;
    logic [GROUP-1:0] grp_sum;
    logic             grp_cout;
    logic             grp_c_msb;

    if (k == 0) begin : g_head
      // Incoming beat; an invalid input simply loads a bubble.
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.carry = cin;
        src.a     = CLA_MAX_WIDTH'(a);
        src.b     = CLA_MAX_WIDTH'(b);
      end
    end else begin : g_link
      assign src = stg_q[k-1];
    end

    cla_group #(
      .GROUP(GROUP)
    ) u_group (
      .a    (src.a[k*GROUP +: GROUP]),
      .b    (src.b[k*GROUP +: GROUP]),
      .cin  (src.carry),
      .sum  (grp_sum),
      .cout (grp_cout),
      .c_msb(grp_c_msb)
    );

    // Pass the beat along with this group's sum bits and carry filled in.
    always_comb begin
      nxt                       = src;
      nxt.sum[k*GROUP +: GROUP] = grp_sum;
      nxt.carry                 = grp_cout;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_q[k] <= '0;
      end else if (en) begin
        stg_q[k] <= nxt;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // Carry into the MSB differing from carry out marks signed overflow.
      assign ovf_d = grp_c_msb ^ grp_cout;
    end else begin : g_mid
      logic unused_c_msb;
      assign unused_c_msb = grp_c_msb;
    end
  end

  assign out_valid = stg_q[STAGES-1].valid;
  assign sum       = stg_q[STAGES-1].sum[WIDTH-1:0];
  assign cout      = stg_q[STAGES-1].carry;

`ifdef CLA_OVF_EN
  logic ovf_q;

  // Registered in step with the final stage so it tracks sum/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_d;
  assign unused_ovf_d = ovf_d;
`endif

endmodule

// File: tb/tb_cla_pipelined_adder.sv
module tb_cla_pipelined_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned G   = 4;
  localparam int unsigned S   = W / G;
  localparam int unsigned NSW = 4;
  localparam int unsigned SW_W [NSW] = '{4, 8, 16, 32};
  localparam int unsigned SW_G [NSW] = '{4, 4, 4, 8};
  localparam int unsigned NB  = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef CLA_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  cla_pipelined_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef CLA_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Parametric sweep instances
  logic        sw_in_valid [NSW];
  logic        sw_in_ready [NSW];
  logic        sw_cin      [NSW];
  logic        sw_out_valid[NSW];
  logic        sw_out_ready[NSW];
  logic        sw_cout     [NSW];
  logic [31:0] sw_a        [NSW];
  logic [31:0] sw_b        [NSW];
  logic [31:0] sw_sum      [NSW];
`ifdef CLA_OVF_EN
  logic        sw_ovf      [NSW];
`endif

  for (genvar d = 0; d < NSW; d++) begin : g_sw
    localparam int unsigned DW = SW_W[d];
    localparam int unsigned DG = SW_G[d];
    logic [DW-1:0] s;
    cla_pipelined_adder #(.WIDTH(DW), .GROUP(DG)) u_sw (
      .clk      (clk),
      .rst      (rst),
      .in_valid (sw_in_valid[d]),
      .in_ready (sw_in_ready[d]),
      .a        (sw_a[d][DW-1:0]),
      .b        (sw_b[d][DW-1:0]),
      .cin      (sw_cin[d]),
      .out_valid(sw_out_valid[d]),
      .out_ready(sw_out_ready[d]),
      .sum      (s),
      .cout     (sw_cout[d])
`ifdef CLA_OVF_EN
      ,
      .ovf      (sw_ovf[d])
`endif
    );
    assign sw_sum[d] = 32'(s);
  end

  typedef struct {
    logic [32:0] res;
    int          acc;
    int          st;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif
  } exp_t;

  // Reference: {cout, sum} of an unbounded integer add, cut to w bits.
  function automatic logic [32:0] ref_add(input int unsigned w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci);
    logic [63:0] full;
    logic [63:0] mask;
    full = 64'(x) + 64'(y) + 64'(ci);
    mask = (64'd1 << w) - 64'd1;
    return {full[w], 32'(full & mask)};
  endfunction

`ifdef CLA_OVF_EN
  // Signed overflow: same-sign operands giving a result of the other sign.
  function automatic logic ref_ovf(input int unsigned w, input logic [31:0] x,
                                   input logic [31:0] y, input logic ci);
    logic [32:0] r;
    r = ref_add(w, x, y, ci);
    return (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
  endfunction
`endif

  task automatic test_reset();
    repeat (3) @(negedge clk);
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef CLA_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid cycle %0d: got %b want 0", n, out_valid); end
    end
  endtask

  task automatic test_wrap();
    logic [32:0] e;
    e = ref_add(W, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; out_ready = 1'b1;
    for (int unsigned n = 1; n <= S; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== (n == S)) begin errors++; $display("FAIL wrap_latency n=%0d: got out_valid %b want %b", n, out_valid, (n == S)); end
    end
    checks++; if (sum !== 16'h0000 || sum !== e[15:0]) begin errors++; $display("FAIL wrap_sum: got %h want 0000", sum); end
    checks++; if (cout !== 1'b1 || cout !== e[32]) begin errors++; $display("FAIL wrap_cout: got %b want 1", cout); end
`ifdef CLA_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3] = '{16'h1234, 16'h8000, 16'h7FFF};
    logic [15:0] tb [3] = '{16'h4321, 16'h8000, 16'h0001};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] es [3] = '{16'h5555, 16'h0001, 16'h8000};
    logic        ec [3] = '{1'b0, 1'b1, 1'b0};
`ifdef CLA_OVF_EN
    logic        eo [3] = '{1'b0, 1'b1, 1'b1};
`endif
    out_ready = 1'b1;
    for (int unsigned i = 0; i <= S + 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (i >= S && i < S + 3)) begin errors++; $display("FAIL b2b_valid i=%0d: got %b", i, out_valid); end
      if (i >= S && i < S + 3) begin
        checks++;
        if (sum !== es[i-S] || cout !== ec[i-S]) begin
          errors++; $display("FAIL b2b_data beat %0d: got %h/%b want %h/%b", i - S, sum, cout, es[i-S], ec[i-S]);
        end
`ifdef CLA_OVF_EN
        checks++; if (ovf !== eo[i-S]) begin errors++; $display("FAIL b2b_ovf beat %0d: got %b want %b", i - S, ovf, eo[i-S]); end
`endif
      end
      if (i < 3) begin
        in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = tc[i];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t        q[$];
    exp_t        e;
    logic [15:0] ba [5];
    logic [15:0] bb [5];
    logic        bc [5];
    int          sent = 0;
    int          got  = 0;
    logic        ordy, en_exp;
    for (int i = 0; i < 5; i++) begin
      ba[i] = 16'($urandom()); bb[i] = 16'($urandom()); bc[i] = 1'($urandom());
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ordy = !(k >= int'(S) && k < int'(S) + 5);
      out_ready = ordy;
      #1;
      en_exp = !out_valid || ordy;
      checks++; if (in_ready !== en_exp) begin errors++; $display("FAIL bp_in_ready k=%0d: got %b want %b", k, in_ready, en_exp); end
      if (!ordy) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid k=%0d: got %b want 1", k, out_valid); end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_spurious k=%0d: got sum %h want no result", k, sum);
        end else begin
          if ({cout, sum} !== {q[0].res[32], q[0].res[15:0]}) begin
            errors++; $display("FAIL bp_data k=%0d: got %b/%h want %b/%h", k, cout, sum, q[0].res[32], q[0].res[15:0]);
          end
          if (ordy) begin void'(q.pop_front()); got++; end
        end
      end
      if (sent < 5) begin
        in_valid = 1'b1; a = ba[sent]; b = bb[sent]; cin = bc[sent];
        if (en_exp) begin
          e.res = ref_add(W, 32'(ba[sent]), 32'(bb[sent]), bc[sent]);
          e.acc = k; e.st = 0;
`ifdef CLA_OVF_EN
          e.ovf = ref_ovf(W, 32'(ba[sent]), 32'(bb[sent]), bc[sent]);
`endif
          q.push_back(e);
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (got != 5 || q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d results (%0d left) want 5", got, q.size()); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom()); b = 16'($urandom()); cin = 1'b1;
      if (k == 2) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs: got %h/%b want 0000/0", sum, cout); end
    for (int unsigned n = 0; n < 2 * S + 4; n++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid n=%0d: got %b want 0", n, out_valid); end
    end
  endtask

  task automatic test_sweep();
    exp_t        sq [NSW][$];
    exp_t        e;
    int          sent  [NSW];
    int          stall [NSW];
    bit          seen  [NSW];
    bit          hold  [NSW];
    logic        ordy  [NSW];
    logic        en_d;
    logic [31:0] mask, x, y;
    int unsigned sd;
    int          cyc = 0;
    int          lat, elat;
    bit          all_done = 0;
    for (int d = 0; d < int'(NSW); d++) begin
      sent[d] = 0; stall[d] = 0; seen[d] = 0; hold[d] = 0;
    end
    while (!all_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < int'(NSW); d++) begin
        ordy[d] = ($urandom_range(0, 3) != 0);
        sw_out_ready[d] = ordy[d];
      end
      #1;
      all_done = 1;
      for (int d = 0; d < int'(NSW); d++) begin
        sd   = SW_W[d] / SW_G[d];
        mask = 32'((64'd1 << SW_W[d]) - 64'd1);
        en_d = !sw_out_valid[d] || ordy[d];
        checks++;
        if (sw_in_ready[d] !== en_d) begin errors++; $display("FAIL sw%0d_in_ready cyc %0d: got %b want %b", d, cyc, sw_in_ready[d], en_d); end
        if (sw_out_valid[d]) begin
          if (sq[d].size() == 0) begin
            checks++; errors++; $display("FAIL sw%0d_spurious cyc %0d: got %h want no result", d, cyc, sw_sum[d]);
          end else begin
            if (!seen[d]) begin
              seen[d] = 1;
              lat  = cyc - sq[d][0].acc;
              elat = int'(sd) + stall[d] - sq[d][0].st;
              checks++; if (lat != elat) begin errors++; $display("FAIL sw%0d_latency cyc %0d: got %0d want %0d", d, cyc, lat, elat); end
            end
            if (ordy[d]) begin
              checks++;
              if ({sw_cout[d], sw_sum[d]} !== sq[d][0].res) begin
                errors++; $display("FAIL sw%0d_data cyc %0d: got %b/%h want %b/%h", d, cyc, sw_cout[d], sw_sum[d], sq[d][0].res[32], sq[d][0].res[31:0]);
              end
`ifdef CLA_OVF_EN
              checks++;
              if (sw_ovf[d] !== sq[d][0].ovf) begin errors++; $display("FAIL sw%0d_ovf cyc %0d: got %b want %b", d, cyc, sw_ovf[d], sq[d][0].ovf); end
`endif
              void'(sq[d].pop_front());
              seen[d] = 0;
            end
          end
        end
        if (!en_d) stall[d]++;
        if (!hold[d]) begin
          if (sent[d] < int'(NB) && $urandom_range(0, 4) != 0) begin
            x = $urandom(); y = $urandom();
            if ($urandom_range(0, 7) == 0) x = '1;
            sw_in_valid[d] = 1'b1; sw_a[d] = x & mask; sw_b[d] = y & mask; sw_cin[d] = 1'($urandom());
          end else begin
            sw_in_valid[d] = 1'b0;
          end
        end
        if (sw_in_valid[d] && en_d) begin
          e.res = ref_add(SW_W[d], sw_a[d], sw_b[d], sw_cin[d]);
          e.acc = cyc; e.st = stall[d];
`ifdef CLA_OVF_EN
          e.ovf = ref_ovf(SW_W[d], sw_a[d], sw_b[d], sw_cin[d]);
`endif
          sq[d].push_back(e);
          sent[d]++;
          hold[d] = 0;
        end else begin
          hold[d] = sw_in_valid[d];
        end
        if (sent[d] < int'(NB) || sq[d].size() != 0 || sw_in_valid[d]) all_done = 0;
      end
    end
    for (int d = 0; d < int'(NSW); d++) sw_in_valid[d] = 1'b0;
    checks++;
    if (!all_done) begin errors++; $display("FAIL sweep_timeout: got %0d cycles without draining want completion", cyc); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < int'(NSW); d++) begin
      sw_in_valid[d] = 1'b0; sw_out_ready[d] = 1'b1; sw_a[d] = '0; sw_b[d] = '0; sw_cin[d] = 1'b0;
    end
    test_reset();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
